fp_normalizer: RTL and testbench

//  Post-add normalisation stage for the single-precision FP calculator datapath.

---
 rtl/fp_pkg.sv | 24 ++
 rtl/fp_normalizer.sv | 133 +++++++++++++
 tb/tb_fp_normalizer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared constants, FSM state encoding and IEEE-754 single packing helper
// for the FP calculator datapath.
package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int MANT_W = 24;
    localparam int FRAC_W = MANT_W - 1;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [EXP_W+FRAC_W:0] pack_fp(
        input logic              sign,
        input logic [EXP_W-1:0]  exp,
        input logic [FRAC_W-1:0] frac
    );
        return {sign, exp, frac};
    endfunction

endpackage

// File: rtl/fp_normalizer.sv
// Post-add normalisation: shifts the mantissa one bit per cycle until the
// hidden bit is set, then packs a truncated IEEE-754 single with flags.
module fp_normalizer
    import fp_pkg::*;
#(
    parameter int MANT_W = fp_pkg::MANT_W,
    parameter int EXP_W  = fp_pkg::EXP_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      start,
    input  logic [MANT_W-1:0]         sum,
    input  logic                      c_out,
    input  logic                      signS,
    input  logic [EXP_W-1:0]          exp_in,
    output logic                      busy,
    output logic                      done,
    output logic [EXP_W+MANT_W-1:0]   result,
    output logic                      zero,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int RES_W = EXP_W + MANT_W;
    localparam logic [EXP_W:0] EXP_INF = {1'b0, EXP_MAX};
    localparam logic [EXP_W:0] EXP_OVF = EXP_INF - 1'b1;

    state_e              state_q, state_d;
    logic [MANT_W-1:0]   mant_q, mant_d;
    logic [EXP_W:0]      exp_q, exp_d;
    logic                sign_q, sign_d;
    logic                carry_q, carry_d;
    logic [RES_W-1:0]    result_q, result_d;
    logic                zero_q, zero_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
    logic [EXP_W:0]      exp_inc;

    // One extra exponent bit so increment/decrement can never wrap.
    assign exp_inc = exp_q + 1'b1;

    // NOTE: every always_comb target gets its hold value first, so no path
    // through the case/if tree can leave a signal unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        mant_d   = mant_q;
        exp_d    = exp_q;
        sign_d   = sign_q;
        carry_d  = carry_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mant_d  = sum;
                    carry_d = c_out;
                    sign_d  = signS;
                    exp_d   = {1'b0, exp_in};
                    zero_d  = 1'b0;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    state_d = NORM;
                end
            end
            NORM: begin
                state_d = DONE;
                if (carry_q) begin
                    if (exp_q >= EXP_OVF) begin
                        ovf_d    = 1'b1;
                        result_d = pack_fp(sign_q, EXP_MAX, '0);
                    end else begin
                        result_d = pack_fp(sign_q, exp_inc[EXP_W-1:0], mant_q[MANT_W-1:1]);
                    end
                end else if (exp_q == EXP_INF) begin
                    ovf_d    = 1'b1;
                    result_d = pack_fp(sign_q, EXP_MAX, '0);
                end else if (mant_q == '0) begin
                    zero_d   = 1'b1;
                    result_d = '0;
                end else if (mant_q[MANT_W-1]) begin
                    result_d = pack_fp(sign_q, exp_q[EXP_W-1:0], mant_q[MANT_W-2:0]);
                end else if (exp_q <= 1) begin
                    unf_d    = 1'b1;
                    result_d = {sign_q, {(RES_W-1){1'b0}}};
                end else begin
                    mant_d  = mant_q << 1;
                    exp_d   = exp_q - 1'b1;
                    state_d = NORM;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge value of every other, independent of process order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mant_q   <= '0;
            exp_q    <= '0;
            sign_q   <= 1'b0;
            carry_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else if (en) begin
            state_q  <= state_d;
            mant_q   <= mant_d;
            exp_q    <= exp_d;
            sign_q   <= sign_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_fp_normalizer.sv
// Scoreboard bench for fp_normalizer: directed corner cases plus random
// requests checked against an arithmetic reference model.
module tb_fp_normalizer;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        start;
    logic [23:0] sum;
    logic        c_out;
    logic        signS;
    logic [7:0]  exp_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic        underflow;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        o;
        logic        u;
        int          lat;
        int          t0;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    fp_normalizer dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .sum(sum),
        .c_out(c_out), .signS(signS), .exp_in(exp_in), .busy(busy),
        .done(done), .result(result), .zero(zero), .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Reference: latency is 2 cycles plus one per left shift; a value whose
    // leading one is k places below the hidden bit needs k shifts, unless the
    // exponent reaches 1 first, which flushes to signed zero.
    function automatic exp_t model(input logic [23:0] m, input logic c,
                                   input logic s, input logic [7:0] e8);
        exp_t r;
        int e = int'(e8);
        int p = -1;
        int k;
        logic [7:0]  eb;
        logic [23:0] sh;
        r.res = '0; r.z = 0; r.o = 0; r.u = 0; r.lat = 2; r.t0 = 0;
        if (c) begin
            if (e >= 254) begin
                r.o = 1; r.res = {s, 8'hFF, 23'd0};
            end else begin
                eb = 8'(e + 1); r.res = {s, eb, m[23:1]};
            end
        end else if (e == 255) begin
            r.o = 1; r.res = {s, 8'hFF, 23'd0};
        end else if (m == 0) begin
            r.z = 1;
        end else begin
            for (int i = 0; i < 24; i++) if (m[i]) p = i;
            k = 23 - p;
            if (k > 0 && e <= k) begin
                r.u = 1; r.res = {s, 31'd0};
                r.lat = 2 + ((e <= 1) ? 0 : e - 1);
            end else begin
                eb = 8'(e - k); sh = m << k;
                r.res = {s, eb, sh[22:0]};
                r.lat = 2 + k;
            end
        end
        return r;
    endfunction

    task automatic issue(input logic [23:0] m, input logic c, input logic s,
                         input logic [7:0] e, input exp_t item, input bit push);
        int w = 0;
        @(negedge clk);
        while (busy && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (busy) begin
            check("idle_timeout", 32'(busy), 32'd0);
            return;
        end
        sum = m; c_out = c; signS = s; exp_in = e; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        item.t0 = cyc;
        if (push) q.push_back(item);
    endtask

    function automatic exp_t lit(input logic [31:0] res, input logic z,
                                 input logic o, input logic u, input int lat);
        exp_t r;
        r.res = res; r.z = z; r.o = o; r.u = u; r.lat = lat; r.t0 = 0;
        return r;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        exp_t it;
        forever begin
            @(negedge clk);
            if (done && !rst) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    it = q.pop_front();
                    check("result", result, it.res);
                    check("zero", 32'(zero), 32'(it.z));
                    check("overflow", 32'(overflow), 32'(it.o));
                    check("underflow", 32'(underflow), 32'(it.u));
                    check("latency", 32'(cyc - it.t0 + 1), 32'(it.lat));
                end
            end
        end
    end

    initial begin
        exp_t ex;
        int n;
        logic [23:0] rm;
        logic [7:0]  re;
        logic        rc, rs;

        rst = 1'b1; en = 1'b1; start = 1'b0;
        sum = '0; c_out = 1'b0; signS = 1'b0; exp_in = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_flags", {29'd0, zero, overflow, underflow}, 32'd0);
        rst = 1'b0;

        issue(24'h800000, 0, 0, 8'd127, lit(32'h3F800000, 0, 0, 0, 2), 1);
        issue(24'h000000, 1, 0, 8'd127, lit(32'h40000000, 0, 0, 0, 2), 1);

        issue(24'h000001, 0, 1, 8'd127, lit(32'hB4000000, 0, 0, 0, 25), 1);
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        check("busy_cycles", 32'(n), 32'd25);

        issue(24'h000000, 0, 1, 8'd100, lit(32'h00000000, 1, 0, 0, 2), 1);
        issue(24'h000000, 1, 0, 8'd254, lit(32'h7F800000, 0, 1, 0, 2), 1);
        issue(24'h123456, 0, 1, 8'd255, lit(32'hFF800000, 0, 1, 0, 2), 1);
        issue(24'h000010, 0, 1, 8'd3,   lit(32'h80000000, 0, 0, 1, 4), 1);

        // en low for 5 cycles mid-shift stretches latency by exactly 5
        issue(24'h000001, 0, 1, 8'd127, lit(32'hB4000000, 0, 0, 0, 30), 1);
        repeat (3) @(negedge clk);
        en = 1'b0;
        repeat (5) @(negedge clk);
        en = 1'b1;

        // a second start during NORM must be dropped
        issue(24'h000001, 0, 1, 8'd127, lit(32'hB4000000, 0, 0, 0, 25), 1);
        repeat (5) @(negedge clk);
        sum = 24'h800000; exp_in = 8'd127; signS = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        // start with en low is not accepted
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        en = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; en = 1'b1;
        repeat (3) @(negedge clk);
        check("en_low_start", 32'(busy), 32'd0);

        // reset in the middle of a shift sequence
        issue(24'h000001, 0, 1, 8'd127, lit(32'h0, 0, 0, 0, 0), 0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_result", result, 32'd0);
        check("midrst_flags", {29'd0, zero, overflow, underflow}, 32'd0);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("midrst_idle", 32'(busy), 32'd0);

        for (int i = 0; i < 300; i++) begin
            rm = 24'($urandom);
            rm = rm >> $urandom_range(0, 24);
            rc = ($urandom_range(0, 7) == 0);
            rs = 1'($urandom);
            case ($urandom_range(0, 3))
                0:       re = 8'($urandom_range(0, 8));
                1:       re = 8'($urandom_range(250, 255));
                default: re = 8'($urandom);
            endcase
            ex = model(rm, rc, rs, re);
            issue(rm, rc, rs, re, ex, 1);
        end

        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
